// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word, RAM handshake state and memory arbiter grant state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side bus of the memory arbiter; slave is the arbiter's view,
// master is the view of the caches and RAM surrounding it.
interface mem_arbiter_if;
   import cpu_types_pkg::*;

   logic      iREN;
   word_t     iaddr;
   logic      iwait;
   word_t     iload;
   logic      dREN;
   logic      dWEN;
   word_t     daddr;
   word_t     dstore;
   logic      dwait;
   word_t     dload;
   logic      ramREN;
   logic      ramWEN;
   word_t     ramaddr;
   word_t     ramstore;
   word_t     ramload;
   ramstate_t ramstate;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
   );

endinterface

// File: rtl/mem_arbiter.sv
// Registered icache/dcache grant FSM in front of the unified RAM port.
// Define ARB_STARVE_GUARD_EN to force an icache grant after STARVE_LIMIT back-to-back dcache grants.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic           clk,
   input  logic           RST,
   mem_arbiter_if.slave   bus
);

   arb_state_t state, nxt;
   logic       drq, iacc, dacc, force_i;

   assign drq  = bus.dREN | bus.dWEN;
   assign iacc = (state == IGNT) && bus.iREN && (bus.ramstate == ACCESS);
   assign dacc = (state == DGNT) && drq && (bus.ramstate == ACCESS);

`ifdef ARB_STARVE_GUARD_EN
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   logic [CW-1:0] cnt;

   assign force_i = bus.iREN && (cnt == LIM);
`else
   assign force_i = 1'b0;
`endif

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state <= IDLE;
`ifdef ARB_STARVE_GUARD_EN
         cnt   <= '0;
`endif
      end else begin
         state <= nxt;
`ifdef ARB_STARVE_GUARD_EN
         // Only dcache completions with the icache still waiting count toward starvation.
         if (iacc)
            cnt <= '0;
         else if (dacc)
            cnt <= !bus.iREN ? '0 : (cnt == LIM) ? cnt : cnt + 1'b1;
`endif
      end
   end

   always_comb begin
      nxt          = state;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;
      bus.iload    = bus.ramload;
      bus.dload    = bus.ramload;
      unique case (state)
         IDLE: begin
            if (drq && !force_i)
               nxt = DGNT;
            else if (bus.iREN)
               nxt = IGNT;
         end
         IGNT: begin
            // Enable follows the live request so a flush drops it in the same cycle.
            bus.ramREN  = bus.iREN;
            bus.ramaddr = bus.iaddr;
            if (!bus.iREN)
               nxt = IDLE;
            else if (iacc) begin
               bus.iwait = 1'b0;
               nxt       = IDLE;
            end
         end
         DGNT: begin
            bus.ramREN   = bus.dREN;
            bus.ramWEN   = bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            if (!drq)
               nxt = IDLE;
            else if (dacc) begin
               bus.dwait = 1'b0;
               nxt       = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; starvation steps run when ARB_STARVE_GUARD_EN is defined.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic clk = 1'b0;
   logic RST = 1'b1;
   int   n_assert = 0;
   int   n_fail = 0;

   mem_arbiter_if bus ();

   mem_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk (clk),
      .RST (RST),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      bus.iREN     = 1'b0;
      bus.iaddr    = '0;
      bus.dREN     = 1'b0;
      bus.dWEN     = 1'b0;
      bus.daddr    = '0;
      bus.dstore   = '0;
      bus.ramload  = 32'h0000_1234;
      bus.ramstate = FREE;
      #1;
      check("rst_iwait", 32'(bus.iwait), 32'd1);
      check("rst_dwait", 32'(bus.dwait), 32'd1);
      check("rst_ramREN", 32'(bus.ramREN), 32'd0);
      check("rst_ramWEN", 32'(bus.ramWEN), 32'd0);
      check("rst_ramaddr", bus.ramaddr, 32'h0);
      check("rst_ramstore", bus.ramstore, 32'h0);
      check("rst_iload", bus.iload, 32'h0000_1234);
      check("rst_dload", bus.dload, 32'h0000_1234);
      tick();
      tick();
      RST = 1'b0;

      // icache miss: BUSY, BUSY, ACCESS
      bus.iREN     = 1'b1;
      bus.iaddr    = 32'h0000_0040;
      bus.ramstate = BUSY;
      #1;
      check("i_idle_ramREN", 32'(bus.ramREN), 32'd0);
      tick();
      check("i_g1_ramREN", 32'(bus.ramREN), 32'd1);
      check("i_g1_ramaddr", bus.ramaddr, 32'h0000_0040);
      check("i_g1_iwait", 32'(bus.iwait), 32'd1);
      tick();
      check("i_g2_ramREN", 32'(bus.ramREN), 32'd1);
      check("i_g2_iwait", 32'(bus.iwait), 32'd1);
      tick();
      bus.ramstate = ACCESS;
      bus.ramload  = 32'h2400_0001;
      #1;
      check("i_acc_iwait", 32'(bus.iwait), 32'd0);
      check("i_acc_iload", bus.iload, 32'h2400_0001);
      check("i_acc_dwait", 32'(bus.dwait), 32'd1);
      tick();
      bus.iREN     = 1'b0;
      bus.ramstate = FREE;
      #1;
      check("i_post_ramREN", 32'(bus.ramREN), 32'd0);
      check("i_post_iwait", 32'(bus.iwait), 32'd1);
      check("i_post_ramaddr", bus.ramaddr, 32'h0);

      // simultaneous requests: dcache first, one idle cycle, then icache
      bus.iREN     = 1'b1;
      bus.dREN     = 1'b1;
      bus.iaddr    = 32'h0000_0040;
      bus.daddr    = 32'h0000_0100;
      bus.ramstate = ACCESS;
      #1;
      check("p_idle_ramREN", 32'(bus.ramREN), 32'd0);
      tick();
      check("p_d_ramaddr", bus.ramaddr, 32'h0000_0100);
      check("p_d_ramREN", 32'(bus.ramREN), 32'd1);
      check("p_d_dwait", 32'(bus.dwait), 32'd0);
      check("p_d_iwait", 32'(bus.iwait), 32'd1);
      bus.dREN = 1'b0;
      tick();
      check("p_idle2_ramREN", 32'(bus.ramREN), 32'd0);
      check("p_idle2_dwait", 32'(bus.dwait), 32'd1);
      tick();
      check("p_i_ramaddr", bus.ramaddr, 32'h0000_0040);
      check("p_i_iwait", 32'(bus.iwait), 32'd0);
      check("p_i_dwait", 32'(bus.dwait), 32'd1);
      bus.iREN     = 1'b0;
      bus.ramstate = FREE;
      tick();

      // dcache write, ACCESS on third granted cycle
      bus.dWEN     = 1'b1;
      bus.daddr    = 32'h0000_0200;
      bus.dstore   = 32'hDEAD_BEEF;
      bus.ramstate = BUSY;
      tick();
      check("w_g1_ramWEN", 32'(bus.ramWEN), 32'd1);
      check("w_g1_ramREN", 32'(bus.ramREN), 32'd0);
      check("w_g1_ramstore", bus.ramstore, 32'hDEAD_BEEF);
      check("w_g1_ramaddr", bus.ramaddr, 32'h0000_0200);
      check("w_g1_dwait", 32'(bus.dwait), 32'd1);
      tick();
      check("w_g2_ramWEN", 32'(bus.ramWEN), 32'd1);
      check("w_g2_ramstore", bus.ramstore, 32'hDEAD_BEEF);
      check("w_g2_dwait", 32'(bus.dwait), 32'd1);
      tick();
      bus.ramstate = ACCESS;
      #1;
      check("w_g3_ramWEN", 32'(bus.ramWEN), 32'd1);
      check("w_g3_ramstore", bus.ramstore, 32'hDEAD_BEEF);
      check("w_g3_dwait", 32'(bus.dwait), 32'd0);
      bus.dWEN = 1'b0;
      tick();
      bus.ramstate = FREE;
      #1;
      check("w_post_ramWEN", 32'(bus.ramWEN), 32'd0);
      check("w_post_dwait", 32'(bus.dwait), 32'd1);
      check("w_post_ramstore", bus.ramstore, 32'h0);

      // icache flush while RAM busy
      bus.iREN     = 1'b1;
      bus.iaddr    = 32'h0000_0080;
      bus.ramstate = BUSY;
      tick();
      check("f_g_ramREN", 32'(bus.ramREN), 32'd1);
      bus.iREN = 1'b0;
      #1;
      check("f_drop_ramREN", 32'(bus.ramREN), 32'd0);
      check("f_drop_iwait", 32'(bus.iwait), 32'd1);
      tick();
      bus.iREN = 1'b1;
      #1;
      check("f_idle_ramREN", 32'(bus.ramREN), 32'd0);
      check("f_idle_iwait", 32'(bus.iwait), 32'd1);
      check("f_idle_ramaddr", bus.ramaddr, 32'h0);
      bus.iREN = 1'b0;
      tick();

      // reset during a dcache grant with ACCESS pending
      bus.dREN     = 1'b1;
      bus.daddr    = 32'h0000_0300;
      bus.ramstate = BUSY;
      tick();
      check("r_g_ramREN", 32'(bus.ramREN), 32'd1);
      bus.ramstate = ACCESS;
      #1;
      RST = 1'b1;
      #1;
      check("r_async_ramREN", 32'(bus.ramREN), 32'd0);
      check("r_async_dwait", 32'(bus.dwait), 32'd1);
      check("r_async_ramaddr", bus.ramaddr, 32'h0);
      tick();
      RST = 1'b0;
      #1;
      check("r_rel_ramREN", 32'(bus.ramREN), 32'd0);
      check("r_rel_dwait", 32'(bus.dwait), 32'd1);
      bus.dREN     = 1'b0;
      bus.ramstate = FREE;
      tick();

`ifdef ARB_STARVE_GUARD_EN
      // starvation guard: grant order D,D,D,D,I,D with idle cycles between
      begin
         logic [31:0] exp_addr [12];
         exp_addr = '{32'h0, 32'h100, 32'h0, 32'h100, 32'h0, 32'h100,
                      32'h0, 32'h100, 32'h0, 32'h40, 32'h0, 32'h100};
         bus.iREN     = 1'b1;
         bus.dREN     = 1'b1;
         bus.iaddr    = 32'h0000_0040;
         bus.daddr    = 32'h0000_0100;
         bus.ramstate = ACCESS;
         #1;
         for (int i = 0; i < 12; i++) begin
            check($sformatf("s_addr_%0d", i), bus.ramaddr, exp_addr[i]);
            check($sformatf("s_ren_%0d", i), 32'(bus.ramREN), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick();
         end
         bus.iREN     = 1'b0;
         bus.dREN     = 1'b0;
         bus.ramstate = FREE;
         tick();
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-CPU memory arbiter directly downstream of the instruction cache. It consumes the icache miss request (iREN, iaddr) and the dcache request, and grants one of them to the unified RAM port.
- It returns the loaded word with a one-cycle wait-release pulse.
- It replaces the purely combinational request muxing with a registered grant FSM, so a grant is held stable for the whole RAM transaction.

Parameters:
- STARVE_LIMIT, 4, number of consecutive dcache grants allowed while iREN is pending before icache is forced (used only with ARB_STARVE_GUARD_EN).

Ports:
- clk  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- iREN  input  1  icache read request
- iaddr  input  32  icache word address
- iwait  output  1  low for exactly the cycle iload is valid
- iload  output  32  instruction word returned
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request (dREN and dWEN are never both high)
- daddr  input  32  dcache address
- dstore  input  32  dcache write data
- dwait  output  1  low for exactly the cycle dload is valid or the write completes
- dload  output  32  data word returned
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramload  input  32  RAM read data
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR

Behaviour:
- Reset values:
  - state IDLE; starve counter 0.
  - iwait=1, dwait=1.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iload and dload track ramload combinationally at all times.
- States: IDLE, IGNT, DGNT (arb_state_t, registered).
- IDLE:
  - RAM enables low; ramaddr=0; ramstore=0; both waits high.
  - Next state: DGNT if dREN or dWEN (dcache priority); else IGNT if iREN; else IDLE.
  - First RAM enable appears the cycle after the request is first seen (1-cycle grant latency).
- IGNT:
  - ramREN=1, ramaddr=iaddr.
  - When ramstate==ACCESS: iwait=0 that cycle, next state IDLE.
- DGNT:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramstate==ACCESS: dwait=0 that cycle, next state IDLE.
- FREE, BUSY or ERROR while granted: hold the grant; waits stay high; the RAM retries indefinitely.
- Requester drops its enable while granted (flush): return to IDLE next cycle; no wait pulse; ram enables follow the dropped request combinationally that same cycle.
- The non-granted wait is always high. A new request raised during a grant is serviced only after returning to IDLE.
- Back-to-back requests: each transaction costs at least ACCESS cycle + 1 IDLE cycle.
- RST mid-transaction: immediate return to IDLE, enables low, counter cleared. No partial completion is reported.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- With the macro:
  - A counter (width $clog2(STARVE_LIMIT+1)) increments on each DGNT->IDLE completion while iREN is high.
  - The counter clears on any IGNT completion, or when iREN is low at a DGNT completion.
  - When counter==STARVE_LIMIT, IDLE selects IGNT over a pending dcache request.
  - The counter saturates at STARVE_LIMIT and never wraps.
- Without the macro: strict dcache priority; no counter logic is present.

Decomposition:
- Add arb_state_t (IDLE, IGNT, DGNT) to cpu_types_pkg next to the existing ramstate_t and word_t.
- ramaddr, ramstore, iaddr, daddr, dstore and the load ports are word_t.
- No sub-module; a single module with one always_ff for state/counter and one always_comb for outputs.

Test Plan:
- Reset then iREN=1, iaddr=0x0000_0040, ramstate=BUSY for 2 cycles then ACCESS, ramload=0x2400_0001 -> ramREN=1 from cycle 1; iwait=0 and iload=0x2400_0001 only in the ACCESS cycle; IDLE next cycle.
- iREN and dREN high simultaneously, daddr=0x100, iaddr=0x40 -> DGNT first with ramaddr=0x100; after dwait pulse, one IDLE cycle, then IGNT with ramaddr=0x40.
- dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF, ACCESS on 3rd granted cycle -> ramWEN=1, ramstore=0xDEAD_BEEF held all 3 cycles; dwait=0 exactly once.
- IGNT active with ramstate=BUSY, iREN dropped -> IDLE next cycle; iwait never low; ramREN low.
- RST asserted during DGNT with ramstate=ACCESS pending -> enables low asynchronously; no dwait pulse; state IDLE after release.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: iREN and dREN both held high, ACCESS every granted cycle -> grant sequence D,D,D,D,I,D…
